dbgu_burst: RTL and testbench
=============================

DBGU_BURST -- requirements
Module: dbgu_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning memory word width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address pointer width in bits (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 120000, meaning maximum clk cycles between command bytes.
REQ-004 SHALL have ports: clk input 1 (system clock); reset input 1 (synchronous, active-high).
REQ-005 SHALL have ports: rx_valid input 1 (byte strobe from UART); rx_data input 8 (received byte).
REQ-006 SHALL have ports: tx_write output 1 (one-cycle send strobe); tx_data output 8 (byte to send); tx_finished input 1 (UART byte done pulse).
REQ-007 SHALL have ports: cts output 1 (high = host must not send); cpu_run output 1; cpu_n_reset output 1.
REQ-008 SHALL have ports: adr_ptr output ADDR_W; data_bus_out output DATA_W; data_bus_in input DATA_W; RW output 1 (1 = read); mem_op output 1; mem_rdy input 1.

Function
REQ-009 SHALL decode opcodes: 0x01 ADR_SET (ADDR_W/8 arg bytes), 0x03 ADR_GET, 0x06 BURST_WR (count N, then N*DATA_W/8 data bytes), 0x07 BURST_RD (count N), 0x20 RUN_CYC (2 bytes, LE), 0x21 CPU_RESET, 0x22 FREERUN (1 byte), 0x30 STATUS.
REQ-010 SHALL assemble and emit all multi-byte fields little-endian.
REQ-011 SHALL use FSM states IDLE, RX_ARGS, RX_WDATA, MEM_ACC, TX_DATA, CPU_RUN, TX_RESP.
REQ-012 SHALL leave IDLE on the first rx_valid and latch the opcode; an unknown opcode SHALL go directly to TX_RESP with NAK (0x02).
REQ-013 SHALL, in RX_ARGS/RX_WDATA, reset an inter-byte counter on every rx_valid; when it reaches TIMEOUT_CYC, discard the partial command, send NAK and return to IDLE.
REQ-014 SHALL NAK a BURST_WR or BURST_RD with N=0, without any memory access.
REQ-015 SHALL, in BURST_WR, issue a write (RW=0, mem_op=1, data_bus_out=assembled word) as soon as each word completes, deasserting cts only while waiting for the next word's bytes; after word N, send one ACK (0x01).
REQ-016 SHALL, in BURST_RD, per word: read (RW=1, mem_op=1), capture data_bus_in on mem_rdy, send DATA_W/8 bytes, then fetch the next word; no ACK after the data.
REQ-017 SHALL hold mem_op and RW stable until the cycle mem_rdy=1, drop mem_op the following cycle and increment adr_ptr by DATA_W/8, wrapping modulo 2^ADDR_W.
REQ-018 SHALL assert tx_write for exactly one cycle per byte, issuing the next byte only after tx_finished for the previous byte.
REQ-019 SHALL return to IDLE only after tx_finished of the last response byte.
REQ-020 SHALL drive cts=1 from command completion (or burst word wait) until the last response byte's tx_finished; rx_valid while cts=1 outside RX states SHALL be ignored.
REQ-021 SHALL, for RUN_CYC with count C>0, set cpu_run=1 for exactly C clk cycles, then cpu_run=0 and ACK; C=0 SHALL ACK immediately with cpu_run unchanged.
REQ-022 SHALL, for CPU_RESET, drive cpu_n_reset=0 for exactly one cycle and then ACK.
REQ-023 SHALL, for FREERUN, set cpu_run to bit 0 of the argument and ACK.
REQ-024 SHALL, for STATUS, send one byte: bit0 cpu_run, bit1 cpu_n_reset, bits7:4 = DATA_W/8.
REQ-025 SHALL, for ADR_GET, send ADDR_W/8 bytes of adr_ptr; ADR_SET SHALL load adr_ptr and ACK.

Reset
REQ-026 SHALL, when reset=1 at a clk edge, force: state IDLE, tx_write 0, mem_op 0, RW 1, cts 0, cpu_run 0, cpu_n_reset 0, adr_ptr 0, data_bus_out 0, all counters 0.
REQ-027 SHALL release cpu_n_reset to 1 on the first clk edge after reset deasserts.
REQ-028 SHALL abandon any in-flight command, burst or transmission on reset, with no ACK/NAK afterwards.

Structure
REQ-029 SHALL take opcodes, ACK/NAK codes and state encoding from a shared package dbgu_pkg.
REQ-030 SHALL place opcode-to-argument-length decode in sub-module dbgu_decode (combinational, parametrised by ADDR_W).

Verification
REQ-031 SHALL check: ADR_SET 01 78 56 34 12, then ADR_GET -> ACK, then bytes 78 56 34 12.
REQ-032 SHALL check: adr_ptr=0x100, BURST_WR N=2, words 0xDEADBEEF,0x01020304 -> writes to 0x100,0x104, single ACK, adr_ptr=0x108.
REQ-033 SHALL check: DATA_W=64, BURST_RD N=1 at adr_ptr=0xFFFFFFF8 with mem_rdy delayed 5 cycles -> 8 LE bytes, adr_ptr wraps to 0.
REQ-034 SHALL check: ADR_SET with only 2 arg bytes, then silence -> NAK after TIMEOUT_CYC cycles, adr_ptr unchanged.
REQ-035 SHALL check: RUN_CYC 20 03 00 -> cpu_run high exactly 3 cycles, then ACK.
REQ-036 SHALL check: reset asserted mid-BURST_RD -> mem_op 0, tx_write silent, cpu_n_reset 0 then 1 one cycle after release.

Source files
------------

// File: rtl/dbgu_pkg.sv
// Shared opcodes, response codes and FSM encoding for the debug UART burst unit.
package dbgu_pkg;
  localparam logic [7:0] OP_ADR_SET   = 8'h01;
  localparam logic [7:0] OP_ADR_GET   = 8'h03;
  localparam logic [7:0] OP_BURST_WR  = 8'h06;
  localparam logic [7:0] OP_BURST_RD  = 8'h07;
  localparam logic [7:0] OP_RUN_CYC   = 8'h20;
  localparam logic [7:0] OP_CPU_RESET = 8'h21;
  localparam logic [7:0] OP_FREERUN   = 8'h22;
  localparam logic [7:0] OP_STATUS    = 8'h30;

  localparam logic [7:0] RSP_ACK = 8'h01;
  localparam logic [7:0] RSP_NAK = 8'h02;

  typedef enum logic [2:0] {
    IDLE, RX_ARGS, RX_WDATA, MEM_ACC, TX_DATA, CPU_RUN, TX_RESP
  } state_t;
endpackage

// File: rtl/dbgu_decode.sv
// Opcode classifier: flags known opcodes and returns the number of argument bytes.
module dbgu_decode import dbgu_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic [7:0] opcode,
  output logic       known,
  output logic [3:0] arg_len
);
  localparam int AB = ADDR_W / 8;

  always_comb begin
    known   = 1'b1;
    arg_len = 4'd0;
    case (opcode)
      OP_ADR_SET:                          arg_len = 4'(AB);
      OP_ADR_GET, OP_CPU_RESET, OP_STATUS: arg_len = 4'd0;
      OP_BURST_WR, OP_BURST_RD, OP_FREERUN: arg_len = 4'd1;
      OP_RUN_CYC:                          arg_len = 4'd2;
      default:                             known = 1'b0;
    endcase
  end
endmodule

// File: rtl/dbgu_burst.sv
// Debug UART command engine: address pointer, burst memory access and CPU run control.
module dbgu_burst import dbgu_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_write,
  output logic [7:0]        tx_data,
  input  logic              tx_finished,
  output logic              cts,
  output logic              cpu_run,
  output logic              cpu_n_reset,
  output logic [ADDR_W-1:0] adr_ptr,
  output logic [DATA_W-1:0] data_bus_out,
  input  logic [DATA_W-1:0] data_bus_in,
  output logic              RW,
  output logic              mem_op,
  input  logic              mem_rdy
);
  localparam int DB  = DATA_W / 8;
  localparam int AB  = ADDR_W / 8;
  localparam int AW  = (ADDR_W > 16) ? ADDR_W : 16;
  localparam int TW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);

  state_t          state;
  logic [7:0]      opcode;
  logic [AW-1:0]   args, args_nx;
  logic [3:0]      arg_cnt, byte_cnt, tx_left, arg_len;
  logic [7:0]      word_cnt;
  logic [15:0]     run_cnt;
  logic [TOW-1:0]  to_cnt;
  logic [TW-1:0]   tx_word;
  logic            tx_busy, known, cmd_done, timed_out;
  logic [7:0]      dec_op;

  assign dec_op = (state == IDLE) ? rx_data : opcode;

  dbgu_decode #(.ADDR_W(ADDR_W)) u_dec (.opcode(dec_op), .known(known), .arg_len(arg_len));

  always_comb begin
    args_nx = args;
    args_nx[{arg_cnt, 3'b000} +: 8] = rx_data;
  end

  // A command is complete on its last argument byte (or its opcode, if it takes none).
  assign cmd_done  = rx_valid && known &&
                     (((state == IDLE) && (arg_len == 4'd0)) ||
                      ((state == RX_ARGS) && (arg_cnt == arg_len - 4'd1)));
  assign timed_out = (to_cnt == TOW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE; tx_write <= 1'b0; tx_data <= '0; mem_op <= 1'b0; RW <= 1'b1;
      cts <= 1'b0; cpu_run <= 1'b0; cpu_n_reset <= 1'b0; adr_ptr <= '0;
      data_bus_out <= '0; opcode <= '0; args <= '0; arg_cnt <= '0; byte_cnt <= '0;
      word_cnt <= '0; run_cnt <= '0; to_cnt <= '0; tx_word <= '0; tx_left <= '0;
      tx_busy <= 1'b0;
    end else begin
      tx_write    <= 1'b0;
      cpu_n_reset <= 1'b1;
      case (state)
        IDLE: if (rx_valid) begin
          opcode <= rx_data; args <= '0; arg_cnt <= '0; to_cnt <= '0;
          if (!known) begin
            state <= TX_RESP; cts <= 1'b1; tx_word <= TW'(RSP_NAK); tx_left <= 4'd1;
          end else if (arg_len != 4'd0) state <= RX_ARGS;
        end
        RX_ARGS:
          if (rx_valid) begin
            args <= args_nx; arg_cnt <= arg_cnt + 4'd1; to_cnt <= '0;
          end else if (timed_out) begin
            state <= TX_RESP; cts <= 1'b1; tx_word <= TW'(RSP_NAK); tx_left <= 4'd1;
          end else to_cnt <= to_cnt + 1'b1;
        RX_WDATA:
          if (rx_valid) begin
            data_bus_out[{byte_cnt, 3'b000} +: 8] <= rx_data;
            to_cnt <= '0;
            if (byte_cnt == 4'(DB - 1)) begin
              byte_cnt <= '0; cts <= 1'b1; mem_op <= 1'b1; RW <= 1'b0; state <= MEM_ACC;
            end else byte_cnt <= byte_cnt + 4'd1;
          end else if (timed_out) begin
            state <= TX_RESP; cts <= 1'b1; tx_word <= TW'(RSP_NAK); tx_left <= 4'd1;
          end else to_cnt <= to_cnt + 1'b1;
        MEM_ACC: if (mem_rdy) begin
          mem_op  <= 1'b0;
          RW      <= 1'b1;
          adr_ptr <= adr_ptr + ADDR_W'(DB);
          if (RW) begin
            tx_word <= TW'(data_bus_in); tx_left <= 4'(DB); state <= TX_DATA;
          end else if (word_cnt == 8'd1) begin
            word_cnt <= '0; tx_word <= TW'(RSP_ACK); tx_left <= 4'd1; state <= TX_RESP;
          end else begin
            word_cnt <= word_cnt - 8'd1; cts <= 1'b0; to_cnt <= '0; state <= RX_WDATA;
          end
        end
        CPU_RUN:
          if (run_cnt == 16'd1) begin
            cpu_run <= 1'b0; run_cnt <= '0; state <= TX_RESP;
          end else run_cnt <= run_cnt - 16'd1;
        TX_DATA, TX_RESP:
          if (!tx_busy) begin
            tx_write <= 1'b1; tx_data <= tx_word[7:0]; tx_word <= tx_word >> 8; tx_busy <= 1'b1;
          end else if (tx_finished) begin
            tx_busy <= 1'b0;
            tx_left <= tx_left - 4'd1;
            if (tx_left == 4'd1) begin
              // Burst reads chain straight into the next fetch; everything else ends here.
              if (state == TX_DATA && opcode == OP_BURST_RD && word_cnt != 8'd1) begin
                word_cnt <= word_cnt - 8'd1; mem_op <= 1'b1; RW <= 1'b1; state <= MEM_ACC;
              end else begin
                word_cnt <= '0; cts <= 1'b0; state <= IDLE;
              end
            end
          end
        default: state <= IDLE;
      endcase

      if (cmd_done) begin
        cts <= 1'b1; state <= TX_RESP; tx_word <= TW'(RSP_ACK); tx_left <= 4'd1;
        case (dec_op)
          OP_ADR_SET: adr_ptr <= args_nx[ADDR_W-1:0];
          OP_ADR_GET: begin
            state <= TX_DATA; tx_word <= TW'(adr_ptr); tx_left <= 4'(AB);
          end
          OP_BURST_WR, OP_BURST_RD:
            if (args_nx[7:0] == 8'd0) tx_word <= TW'(RSP_NAK);
            else begin
              word_cnt <= args_nx[7:0]; byte_cnt <= '0;
              if (dec_op == OP_BURST_WR) begin
                state <= RX_WDATA; cts <= 1'b0; to_cnt <= '0;
              end else begin
                state <= MEM_ACC; mem_op <= 1'b1; RW <= 1'b1;
              end
            end
          OP_RUN_CYC:
            if (args_nx[15:0] != 16'd0) begin
              state <= CPU_RUN; cpu_run <= 1'b1; run_cnt <= args_nx[15:0];
            end
          OP_CPU_RESET: cpu_n_reset <= 1'b0;
          OP_FREERUN:   cpu_run <= args_nx[0];
          OP_STATUS:    tx_word <= TW'({4'(DB), 2'b00, cpu_n_reset, cpu_run});
          default:      tx_word <= TW'(RSP_NAK);
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dbgu_burst.sv
// Directed bench: command table on a 32-bit instance, plus timeout, run, wrap and reset sequences.
module tb_dbgu_burst;
  localparam int TO = 200;

  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rxv32 = 1'b0, rxv64 = 1'b0;

  logic        tw32, tf32 = 1'b0, cts32, run32, nrst32, rw32, op32, rdy32 = 1'b0;
  logic [7:0]  td32;
  logic [31:0] adr32, dout32, din32 = '0;
  logic        tw64, tf64 = 1'b0, cts64, run64, nrst64, rw64, op64, rdy64 = 1'b0;
  logic [7:0]  td64;
  logic [31:0] adr64;
  logic [63:0] dout64, din64 = '0;

  always #5 clk = ~clk;

  dbgu_burst #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) u32 (
    .clk(clk), .reset(reset), .rx_valid(rxv32), .rx_data(rx_data),
    .tx_write(tw32), .tx_data(td32), .tx_finished(tf32), .cts(cts32),
    .cpu_run(run32), .cpu_n_reset(nrst32), .adr_ptr(adr32), .data_bus_out(dout32),
    .data_bus_in(din32), .RW(rw32), .mem_op(op32), .mem_rdy(rdy32));

  dbgu_burst #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(TO)) u64 (
    .clk(clk), .reset(reset), .rx_valid(rxv64), .rx_data(rx_data),
    .tx_write(tw64), .tx_data(td64), .tx_finished(tf64), .cts(cts64),
    .cpu_run(run64), .cpu_n_reset(nrst64), .adr_ptr(adr64), .data_bus_out(dout64),
    .data_bus_in(din64), .RW(rw64), .mem_op(op64), .mem_rdy(rdy64));

  int pass = 0, total = 0, ovl = 0, stick = 0;
  logic [7:0]  q32[$], q64[$];
  logic [31:0] madr32[$], mdat32[$], madr64[$];
  logic        mrw32[$];
  int run_hi32 = 0, nrst_lo32 = 0;

  // UART models: accept a byte, pulse tx_finished three cycles later
  int tc32 = 0, tc64 = 0;
  logic tb32 = 1'b0, tb64 = 1'b0;
  always @(negedge clk) begin
    tf32 = 1'b0;
    if (reset) tb32 = 1'b0;
    else if (tb32) begin
      if (tc32 == 0) begin tf32 = 1'b1; tb32 = 1'b0; end else tc32--;
    end
    if (tw32) begin if (tb32) ovl++; q32.push_back(td32); tb32 = 1'b1; tc32 = 2; end
  end
  always @(negedge clk) begin
    tf64 = 1'b0;
    if (reset) tb64 = 1'b0;
    else if (tb64) begin
      if (tc64 == 0) begin tf64 = 1'b1; tb64 = 1'b0; end else tc64--;
    end
    if (tw64) begin if (tb64) ovl++; q64.push_back(td64); tb64 = 1'b1; tc64 = 2; end
  end

  // Memory models with programmable ready latency; mem_op must drop right after ready
  int md32 = 0, mc32 = 0, md64 = 0, mc64 = 0;
  logic ms32 = 1'b0, ms64 = 1'b0;
  always @(negedge clk) begin
    rdy32 = 1'b0;
    if (!op32 || reset) begin ms32 = 1'b0; mc32 = 0; end
    else if (ms32) stick++;
    else if (mc32 >= md32) begin
      rdy32 = 1'b1; ms32 = 1'b1; din32 = 32'hA1B2C3D4;
      madr32.push_back(adr32); mdat32.push_back(dout32); mrw32.push_back(rw32);
    end else mc32++;
  end
  always @(negedge clk) begin
    rdy64 = 1'b0;
    if (!op64 || reset) begin ms64 = 1'b0; mc64 = 0; end
    else if (ms64) stick++;
    else if (mc64 >= md64) begin
      rdy64 = 1'b1; ms64 = 1'b1; din64 = 64'h8877665544332211; madr64.push_back(adr64);
    end else mc64++;
  end

  always @(negedge clk) begin
    if (run32) run_hi32++;
    if (!nrst32 && !reset) nrst_lo32++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic bound_fail(input string nm);
    total++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    int t = 0;
    while (((sel == 0) ? cts32 : cts64) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) bound_fail("cts_wait");
    rx_data = b;
    if (sel == 0) rxv32 = 1'b1; else rxv64 = 1'b1;
    @(negedge clk);
    rxv32 = 1'b0; rxv64 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int sel);
    int t = 0;
    while (((sel == 0) ? cts32 : cts64) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) bound_fail("resp_wait");
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [79:0] cmd;  int ncmd;
    logic [63:0] rsp;  int nrsp;
    logic [31:0] adr;  int nmem;
  } vec_t;
  vec_t v[15];

  initial begin
    int m0, t;
    v[0]  = '{80'h12345678_01, 5, 64'h01, 1, 32'h12345678, 0};
    v[1]  = '{80'h03, 1, 64'h12345678, 4, 32'h12345678, 0};
    v[2]  = '{80'h30, 1, 64'h42, 1, 32'h12345678, 0};
    v[3]  = '{80'h0122, 2, 64'h01, 1, 32'h12345678, 0};
    v[4]  = '{80'h30, 1, 64'h43, 1, 32'h12345678, 0};
    v[5]  = '{80'h0022, 2, 64'h01, 1, 32'h12345678, 0};
    v[6]  = '{80'h55, 1, 64'h02, 1, 32'h12345678, 0};
    v[7]  = '{80'h0006, 2, 64'h02, 1, 32'h12345678, 0};
    v[8]  = '{80'h0007, 2, 64'h02, 1, 32'h12345678, 0};
    v[9]  = '{80'h000020, 3, 64'h01, 1, 32'h12345678, 0};
    v[10] = '{80'h21, 1, 64'h01, 1, 32'h12345678, 0};
    v[11] = '{80'h00000100_01, 5, 64'h01, 1, 32'h00000100, 0};
    v[12] = '{80'h01020304_DEADBEEF_02_06, 10, 64'h01, 1, 32'h00000108, 2};
    v[13] = '{80'h0107, 2, 64'hA1B2C3D4, 4, 32'h0000010C, 1};
    v[14] = '{80'h03, 1, 64'h0000010C, 4, 32'h0000010C, 0};

    repeat (3) @(negedge clk);
    chk("rst_ctl32", {58'd0, tw32, op32, rw32, cts32, run32, nrst32}, 64'b001000);
    chk("rst_adr32", {32'd0, adr32}, 64'd0);
    chk("rst_dout32", {32'd0, dout32}, 64'd0);
    chk("rst_ctl64", {59'd0, op64, rw64, cts64, run64, nrst64}, 64'b01000);
    reset = 1'b0;
    @(negedge clk);
    chk("nrst_release", {63'd0, nrst32}, 64'd1);

    for (int i = 0; i < 15; i++) begin
      m0 = madr32.size();
      q32.delete();
      nrst_lo32 = 0;
      for (int b = 0; b < v[i].ncmd; b++) send_byte(0, v[i].cmd[b*8 +: 8]);
      wait_done(0);
      chk($sformatf("v%0d_nrsp", i), 64'(q32.size()), 64'(v[i].nrsp));
      for (int b = 0; b < v[i].nrsp && b < q32.size(); b++)
        chk($sformatf("v%0d_rsp%0d", i, b), {56'd0, q32[b]}, {56'd0, v[i].rsp[b*8 +: 8]});
      chk($sformatf("v%0d_adr", i), {32'd0, adr32}, {32'd0, v[i].adr});
      chk($sformatf("v%0d_nmem", i), 64'(madr32.size() - m0), 64'(v[i].nmem));
      if (i == 10) chk("cpu_reset_low", 64'(nrst_lo32), 64'd1);
    end

    chk("wr0_adr", {32'd0, madr32[0]}, 64'h100);
    chk("wr0_dat", {32'd0, mdat32[0]}, 64'hDEADBEEF);
    chk("wr0_rw", {63'd0, mrw32[0]}, 64'd0);
    chk("wr1_adr", {32'd0, madr32[1]}, 64'h104);
    chk("wr1_dat", {32'd0, mdat32[1]}, 64'h01020304);
    chk("rd_adr", {32'd0, madr32[2]}, 64'h108);
    chk("rd_rw", {63'd0, mrw32[2]}, 64'd1);

    // RUN_CYC 3: cpu_run high exactly three cycles, then ACK
    q32.delete(); run_hi32 = 0;
    send_byte(0, 8'h20); send_byte(0, 8'h03); send_byte(0, 8'h00);
    wait_done(0);
    chk("run_cycles", 64'(run_hi32), 64'd3);
    chk("run_after", {63'd0, run32}, 64'd0);
    chk("run_ack", {56'd0, q32[0]}, 64'h01);
    chk("run_nrsp", 64'(q32.size()), 64'd1);

    // Partial ADR_SET then silence: NAK after the timeout, pointer untouched
    q32.delete();
    send_byte(0, 8'h01); send_byte(0, 8'hAA);
    rx_data = 8'hBB; rxv32 = 1'b1;
    @(negedge clk); rxv32 = 1'b0;
    t = 0;
    while (q32.size() == 0 && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) bound_fail("timeout_nak");
    chk("to_latency", {63'd0, (t >= TO && t <= TO + 3)}, 64'd1);
    wait_done(0);
    chk("to_nak", {56'd0, q32[0]}, 64'h02);
    chk("to_adr", {32'd0, adr32}, 64'h10C);

    // 64-bit read at the top of memory with slow ready: 8 LE bytes, pointer wraps
    md64 = 5; q64.delete();
    send_byte(1, 8'h01); send_byte(1, 8'hF8); send_byte(1, 8'hFF);
    send_byte(1, 8'hFF); send_byte(1, 8'hFF);
    wait_done(1);
    chk("w64_set_ack", {56'd0, q64[0]}, 64'h01);
    q64.delete();
    send_byte(1, 8'h07); send_byte(1, 8'h01);
    wait_done(1);
    chk("w64_nrsp", 64'(q64.size()), 64'd8);
    for (int b = 0; b < 8 && b < q64.size(); b++)
      chk($sformatf("w64_b%0d", b), {56'd0, q64[b]}, 64'(b * 8'h11 + 8'h11));
    chk("w64_rdadr", {32'd0, madr64[0]}, 64'hFFFFFFF8);
    chk("w64_wrap", {32'd0, adr64}, 64'd0);

    // Reset in the middle of a burst read
    md64 = 40; q64.delete();
    send_byte(1, 8'h07); send_byte(1, 8'h02);
    repeat (3) @(negedge clk);
    chk("mid_inflight", {63'd0, op64}, 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_ctl", {59'd0, op64, tw64, cts64, nrst64, run64}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_nrst_rel", {63'd0, nrst64}, 64'd1);
    repeat (60) @(negedge clk);
    chk("mid_tx_silent", 64'(q64.size()), 64'd0);
    chk("mid_memop", {63'd0, op64}, 64'd0);

    chk("tx_overlap", 64'(ovl), 64'd0);
    chk("memop_hold", 64'(stick), 64'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
